// File: rtl/ssd1306_pkg.sv
// Shared constants and types for the SSD1306 SPI panel driver:
// the fixed init command list, frame geometry and the sequencer states.
package ssd1306_pkg;

  localparam int INIT_LEN    = 15;
  localparam int FRAME_BYTES = 1024;

  // Horizontal addressing (20 00) keeps panel auto-increment aligned with pixel_address order
  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hAF
  };

  typedef enum logic [2:0] {
    PWR_WAIT,
    RST_LOW,
    CMD_LOAD,
    DATA_LOAD,
    FETCH,
    SHIFT
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    return (int'(idx) < INIT_LEN) ? INIT_CMDS[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/ssd1306_spi_shifter.sv
// SPI byte serialiser: MSB first, SCLK idles high, SDIN only moves while SCLK is low.
// byte_done is combinational so the sequencer can reload on the same edge the byte ends.
module ssd1306_spi_shifter
  import ssd1306_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       sdin,
  output logic       busy,
  output logic       byte_done
);

  localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic              half_end;

  assign half_end  = (half_cnt == HALF_W'(SCLK_HALF - 1));
  assign byte_done = busy && sclk && half_end && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      half_cnt  <= '0;
      sclk      <= 1'b1;
      sdin      <= 1'b0;
      busy      <= 1'b0;
    end else if (load) begin
      shift_reg <= {data[6:0], 1'b0};
      sdin      <= data[7];
      sclk      <= 1'b0;
      busy      <= 1'b1;
      bit_cnt   <= 3'd0;
      half_cnt  <= '0;
    end else if (busy) begin
      if (half_end) begin
        half_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (bit_cnt == 3'd7) begin
          busy <= 1'b0;
        end else begin
          // Next bit is presented together with the falling edge
          sclk      <= 1'b0;
          sdin      <= shift_reg[7];
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_driver.sv
// SSD1306 panel driver: power-up/reset sequencing, init command list, then endless
// refresh of the 1024-byte frame read from the text engine.
module ssd1306_spi_driver
  import ssd1306_pkg::*;
#(
  parameter logic [31:0] STARTUP_WAIT = 32'd10_000_000,
  parameter int          SCLK_HALF    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pixel_address,
  input  logic [7:0] pixel_data,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       io_reset,
  output logic       frame_done
);

  state_t      state, next_state;
  logic [31:0] wait_cnt;
  logic [3:0]  cmd_idx;
  logic        wait_done;
  logic        load;
  logic [7:0]  load_byte;
  logic        busy;
  logic        byte_done;

  assign wait_done = (wait_cnt == STARTUP_WAIT - 32'd1);

  ssd1306_spi_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (load_byte),
    .sclk      (io_sclk),
    .sdin      (io_sdin),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PWR_WAIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_byte  = 8'h00;
    case (state)
      PWR_WAIT: if (wait_done) next_state = RST_LOW;
      RST_LOW:  if (wait_done) next_state = CMD_LOAD;
      CMD_LOAD: if (!busy) begin
        load       = 1'b1;
        load_byte  = init_cmd(cmd_idx);
        next_state = SHIFT;
      end
      FETCH:    next_state = DATA_LOAD;
      DATA_LOAD: if (!busy) begin
        load       = 1'b1;
        load_byte  = pixel_data;
        next_state = SHIFT;
      end
      SHIFT: if (byte_done) begin
        // io_dc low means we are still walking the init command list
        if (!io_dc && cmd_idx != 4'(INIT_LEN - 1)) next_state = CMD_LOAD;
        else                                       next_state = FETCH;
      end
      default: next_state = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt      <= 32'd0;
      cmd_idx       <= 4'd0;
      pixel_address <= 10'd0;
      io_cs         <= 1'b1;
      io_dc         <= 1'b0;
      io_reset      <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        PWR_WAIT: begin
          wait_cnt <= wait_done ? 32'd0 : wait_cnt + 32'd1;
          if (wait_done) io_reset <= 1'b0;
        end
        RST_LOW: begin
          wait_cnt <= wait_done ? 32'd0 : wait_cnt + 32'd1;
          if (wait_done) begin
            io_reset <= 1'b1;
            io_cs    <= 1'b0;
          end
        end
        CMD_LOAD:  io_dc <= 1'b0;
        DATA_LOAD: io_dc <= 1'b1;
        SHIFT: if (byte_done) begin
          if (!io_dc) begin
            if (cmd_idx == 4'(INIT_LEN - 1)) io_dc   <= 1'b1;
            else                             cmd_idx <= cmd_idx + 4'd1;
          end else begin
            pixel_address <= pixel_address + 10'd1;
            if (pixel_address == 10'(FRAME_BYTES - 1)) frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_driver.sv
// Bench for ssd1306_spi_driver: two instances (SCLK_HALF 1 and 3) with text-engine models,
// an SPI pin decoder and a byte-stream reference built from the init list and frame memory.
module tb_ssd1306_spi_driver;

  localparam logic [31:0] SW = 32'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic sclk_a, sdin_a, cs_a, dc_a, rstp_a, fd_a;
  logic sclk_b, sdin_b, cs_b, dc_b, rstp_b, fd_b;

  ssd1306_spi_driver #(.STARTUP_WAIT(SW), .SCLK_HALF(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_address(addr_a), .pixel_data(data_a),
    .io_sclk(sclk_a), .io_sdin(sdin_a), .io_cs(cs_a), .io_dc(dc_a),
    .io_reset(rstp_a), .frame_done(fd_a));

  ssd1306_spi_driver #(.STARTUP_WAIT(SW), .SCLK_HALF(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_address(addr_b), .pixel_data(data_b),
    .io_sclk(sclk_b), .io_sdin(sdin_b), .io_cs(cs_b), .io_dc(dc_b),
    .io_reset(rstp_b), .frame_done(fd_b));

  // Text engine models: registered read, one clock of latency
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  always @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
  end

  logic [7:0] init_ref [15] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hAF};

  int tests = 0;
  int failed = 0;

  int unsigned tick = 0;
  always @(negedge clk) tick <= tick + 1;

  // Pin-level decoder: captured {dc, byte} plus completion tick per instance
  logic [8:0]  q_a [$];
  logic [8:0]  q_b [$];
  int unsigned t_a [$];
  int unsigned t_b [$];

  logic       v_sclk [2], v_sdin [2], v_dc [2], v_fd [2];
  logic [9:0] v_addr [2];
  assign v_sclk[0] = sclk_a; assign v_sclk[1] = sclk_b;
  assign v_sdin[0] = sdin_a; assign v_sdin[1] = sdin_b;
  assign v_dc[0]   = dc_a;   assign v_dc[1]   = dc_b;
  assign v_fd[0]   = fd_a;   assign v_fd[1]   = fd_b;
  assign v_addr[0] = addr_a; assign v_addr[1] = addr_b;

  int         bitn [2]       = '{0, 0};
  logic [7:0] shr [2]        = '{8'h00, 8'h00};
  logic       psclk [2]      = '{1'b1, 1'b1};
  logic       psdin [2]      = '{1'b0, 1'b0};
  logic       pfd [2]        = '{1'b0, 1'b0};
  int         lo_run [2]     = '{0, 0};
  int         hi_run [2]     = '{0, 0};
  int         sdin_viol [2]  = '{0, 0};
  int         lvl_viol [2]   = '{0, 0};
  int         fd_cnt [2]     = '{0, 0};
  int         fd_wide [2]    = '{0, 0};
  int         fd_data_at [2] = '{0, 0};
  logic [9:0] fd_addr [2]    = '{10'h3FF, 10'h3FF};
  int         data_cnt [2]   = '{0, 0};

  function automatic int sh_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        bitn[d] = 0; psclk[d] = 1'b1; psdin[d] = 1'b0; pfd[d] = 1'b0;
        lo_run[d] = 0; hi_run[d] = 0; data_cnt[d] = 0;
        if (d == 0) begin q_a.delete(); t_a.delete(); end
        else        begin q_b.delete(); t_b.delete(); end
      end else begin
        if (v_sdin[d] !== psdin[d] && v_sclk[d] !== 1'b0) sdin_viol[d]++;
        if (v_sclk[d] === 1'b1 && psclk[d] === 1'b0) begin
          if (lo_run[d] != sh_of(d)) lvl_viol[d]++;
          shr[d] = {shr[d][6:0], v_sdin[d]};
          bitn[d]++;
          if (bitn[d] == 8) begin
            bitn[d] = 0;
            if (d == 0) begin q_a.push_back({v_dc[d], shr[d]}); t_a.push_back(tick); end
            else        begin q_b.push_back({v_dc[d], shr[d]}); t_b.push_back(tick); end
            if (v_dc[d]) data_cnt[d]++;
          end
        end
        if (v_sclk[d] === 1'b0 && psclk[d] === 1'b1 && hi_run[d] < sh_of(d)) lvl_viol[d]++;
        if (v_sclk[d] === 1'b0) begin lo_run[d]++; hi_run[d] = 0; end
        else                    begin hi_run[d]++; lo_run[d] = 0; end
        if (v_fd[d]) begin
          if (pfd[d]) fd_wide[d]++;
          else begin
            fd_cnt[d]++;
            fd_data_at[d] = data_cnt[d];
            fd_addr[d] = v_addr[d];
          end
        end
        psclk[d] = v_sclk[d]; psdin[d] = v_sdin[d]; pfd[d] = v_fd[d];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic wait_cap(input int d, input int n, input int budget, input string name);
    int k = 0;
    while (qsize(d) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(qsize(d) >= n), 32'd1);
  endtask

  // Reference stream: 15 init commands, then frame bytes in address order, wrapping at 1024
  task automatic check_stream(input int d, input int n, input string name);
    int lim = (qsize(d) < n) ? qsize(d) : n;
    int sh = sh_of(d);
    for (int i = 0; i < lim; i++) begin
      logic [8:0]  got, exp;
      int unsigned gap;
      got = (d == 0) ? q_a[i] : q_b[i];
      if (i < 15) exp = {1'b0, init_ref[i]};
      else        exp = {1'b1, (d == 0) ? mem_a[(i - 15) % 1024] : mem_b[(i - 15) % 1024]};
      check($sformatf("%s_byte%0d", name, i), 32'(got), 32'(exp));
      if (i > 0) begin
        gap = (d == 0) ? (t_a[i] - t_a[i-1]) : (t_b[i] - t_b[i-1]);
        check($sformatf("%s_gap%0d", name, i), gap, 32'((i < 15) ? 16*sh + 1 : 16*sh + 2));
      end
    end
  endtask

  typedef struct {
    int   cyc;
    logic rst;
    logic cs;
    logic sclk;
    logic dc;
  } vec_t;

  vec_t vecs [6];

  task automatic applyStimulus();
    int cyc = 0;
    int guard = 0;
    int cmds = 0;

    vecs[0] = '{0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{7, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{9, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'($urandom);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_sclk", 32'(sclk_a), 32'd1);
    check("rst_sdin", 32'(sdin_a), 32'd0);
    check("rst_cs", 32'(cs_a), 32'd1);
    check("rst_dc", 32'(dc_a), 32'd0);
    check("rst_ioreset", 32'(rstp_a), 32'd1);
    check("rst_fd", 32'(fd_a), 32'd0);
    check("rst_cs_b", 32'(cs_b), 32'd1);

    rst_n = 1'b1;
    for (int v = 0; v < 6; v++) begin
      while (cyc < vecs[v].cyc) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("start_c%0d_ioreset", vecs[v].cyc), 32'(rstp_a), 32'(vecs[v].rst));
      check($sformatf("start_c%0d_cs", vecs[v].cyc), 32'(cs_a), 32'(vecs[v].cs));
      check($sformatf("start_c%0d_sclk", vecs[v].cyc), 32'(sclk_a), 32'(vecs[v].sclk));
      check($sformatf("start_c%0d_dc", vecs[v].cyc), 32'(dc_a), 32'(vecs[v].dc));
      check($sformatf("start_c%0d_sclk_b", vecs[v].cyc), 32'(sclk_b), 32'(vecs[v].sclk));
    end

    wait_cap(0, 15 + 1026, 25000, "frame_a_bytes");
  endtask

  task automatic checkOutput();
    int cmds = 0;
    int guard = 0;

    check_stream(0, 15 + 1026, "a");
    check_stream(1, 115, "b");
    for (int i = 0; i < q_a.size(); i++) if (!q_a[i][8]) cmds++;
    check("a_cmd_count", 32'(cmds), 32'd15);
    check("a_fd_pulses", 32'(fd_cnt[0]), 32'd1);
    check("a_fd_wide", 32'(fd_wide[0]), 32'd0);
    check("a_fd_data_count", 32'(fd_data_at[0]), 32'd1024);
    check("a_fd_addr", 32'(fd_addr[0]), 32'd0);
    check("a_sdin_while_high", 32'(sdin_viol[0]), 32'd0);
    check("b_sdin_while_high", 32'(sdin_viol[1]), 32'd0);
    check("a_sclk_levels", 32'(lvl_viol[0]), 32'd0);
    check("b_sclk_levels", 32'(lvl_viol[1]), 32'd0);

    // Asynchronous reset in the middle of a data byte
    while (!(sclk_a === 1'b0 && dc_a === 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midbyte_found", 32'(guard < 100), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_cs", 32'(cs_a), 32'd1);
    check("async_sclk", 32'(sclk_a), 32'd1);
    check("async_addr", 32'(addr_a), 32'd0);
    check("async_dc", 32'(dc_a), 32'd0);
    check("async_sdin", 32'(sdin_a), 32'd0);
    check("async_cs_b", 32'(cs_b), 32'd1);
    check("async_sclk_b", 32'(sclk_b), 32'd1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    rst_n = 1'b1;
    wait_cap(0, 18, 1000, "restart_a_bytes");
    check_stream(0, 18, "restart");
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
